// File: rtl/stream_prefix_pkg.sv
// Shared types and the per-beat arithmetic for the stream_prefix stage.
// Latency: n/a (combinational helper only).
// Backpressure: n/a.
package stream_prefix_pkg;

  // The helper works on a wide word; callers keep only their low DW bits.
  // Modulo-2^DW sums and differences are exactly the low bits of the wide result.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_PSUM = 2'd1,
    MODE_DIFF = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    word_t r;    // result word for this beat
    word_t acc;  // accumulator value after this beat
  } calc_t;

  // On the first beat of a packet the accumulator is treated as zero.
  // Reserved mode 3 behaves like pass-through.
  function automatic calc_t prefix_calc(mode_e mode, word_t d, word_t acc, logic first);
    word_t a;
    calc_t c;
    a     = first ? '0 : acc;
    c.r   = d;
    c.acc = a;
    case (mode)
      MODE_PSUM: begin
        c.r   = a + d;
        c.acc = a + d;
      end
      MODE_DIFF: begin
        c.r   = d - a;
        c.acc = d;
      end
      default: begin
        c.r   = d;
        c.acc = a;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stream_prefix_skid.sv
// Two-entry main+skid register slice for a valid/ready stream of W-bit words.
// Latency: one cycle from input handshake to m_valid_o when the output is not stalled.
// Backpressure: s_ready_o is registered and drops only once both entries will be full.
module axis_skid #(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic         busy_o
);

  logic         main_vld_q, main_vld_d;
  logic [W-1:0] main_dat_q, main_dat_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         s_ready_q, s_ready_d;
  logic         consume;
  logic         accept;

  assign consume = main_vld_q & m_ready_i;
  assign accept  = s_valid_i & s_ready_q;

  // Route each accepted word to main or skid and refill main from skid, keeping order.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (consume) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
        if (accept) begin
          skid_vld_d = 1'b1;
          skid_dat_d = s_data_i;
        end
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_dat_d = s_data_i;
        end
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = s_data_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = s_data_i;
      end
    end
    // Ready for next cycle exactly when the skid entry will be free.
    s_ready_d = ~skid_vld_d;
  end

  // Storage and registered ready; everything clears on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      s_ready_q  <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = main_vld_q;
  assign m_data_o  = main_dat_q;
  assign busy_o    = main_vld_q | skid_vld_q;

endmodule

// File: rtl/stream_prefix.sv
// Per-packet stream transform: pass-through, running prefix sum or first difference.
// Latency: one cycle from input handshake to M_AXIS when the output is not stalled.
// Backpressure: registered S_AXIS_TREADY via a main+skid slice; full rate with M_AXIS_TREADY high.
module stream_prefix
  import stream_prefix_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESET,
  input  logic [1:0]    MODE,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  input  logic [DW-1:0] S_AXIS_TDATA,
  input  logic [3:0]    S_AXIS_TSTRB,
  input  logic          S_AXIS_TLAST,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic [3:0]    M_AXIS_TSTRB,
  output logic          M_AXIS_TLAST,
  output logic [CW-1:0] PKT_CNT,
  output logic          BUSY
);

  localparam int SW = DW + 1;

  logic          in_pkt_q, in_pkt_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  logic          s_rdy;
  logic          accept;
  logic          stage_busy;
  mode_e         mode_eff;
  calc_t         calc;
  logic [SW-1:0] res_dat;
  logic [SW-1:0] out_dat;

  // Upstream always drives full strobes; the strobe carries no information here.
  logic tstrb_unused;
  assign tstrb_unused = ^S_AXIS_TSTRB;

  assign accept = S_AXIS_TVALID & s_rdy;

  // Compute this beat's result; the first beat of a packet uses the live MODE input.
  always_comb begin
    mode_eff = in_pkt_q ? mode_q : mode_e'(MODE);
    calc     = prefix_calc(mode_eff, word_t'(S_AXIS_TDATA), word_t'(acc_q), ~in_pkt_q);
    res_dat  = {S_AXIS_TLAST, calc.r[DW-1:0]};
  end

  // Upper bits of the wide helper result are discarded by design.
  if (DW < MAX_W) begin : g_hi
    logic calc_hi_unused;
    assign calc_hi_unused = ^{calc.r[MAX_W-1:DW], calc.acc[MAX_W-1:DW]};
  end

  // Packet-level state: mode latch, accumulator, and clearing at TLAST.
  always_comb begin
    in_pkt_d = in_pkt_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    if (accept) begin
      if (!in_pkt_q) begin
        mode_d = mode_eff;
      end
      if (S_AXIS_TLAST) begin
        in_pkt_d = 1'b0;
        acc_d    = '0;
      end else begin
        in_pkt_d = 1'b1;
        acc_d    = calc.acc[DW-1:0];
      end
    end
  end

  // Count packets as their last beat leaves on the output handshake.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
      pkt_cnt_d = pkt_cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any packet in progress.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      in_pkt_q  <= 1'b0;
      mode_q    <= MODE_PASS;
      acc_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      in_pkt_q  <= in_pkt_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  axis_skid #(
    .W (SW)
  ) u_skid (
    .clk_i     (AXIS_ACLK),
    .rst_i     (AXIS_ARESET),
    .s_valid_i (S_AXIS_TVALID),
    .s_ready_o (s_rdy),
    .s_data_i  (res_dat),
    .m_valid_o (M_AXIS_TVALID),
    .m_ready_i (M_AXIS_TREADY),
    .m_data_o  (out_dat),
    .busy_o    (stage_busy)
  );

  assign S_AXIS_TREADY = s_rdy;
  assign M_AXIS_TDATA  = out_dat[DW-1:0];
  assign M_AXIS_TLAST  = out_dat[DW];
  assign M_AXIS_TSTRB  = 4'hf;
  assign PKT_CNT       = pkt_cnt_q;
  assign BUSY          = in_pkt_q | stage_busy;

endmodule

// File: tb/tb_stream_prefix.sv
// Bench for stream_prefix: packet-level reference model plus literal expectations.
module tb_stream_prefix;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [3:0]    s_tstrb = 4'hf;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tstrb;
  logic          m_tlast;
  logic [CW-1:0] pkt_cnt;
  logic          busy;

  always #5 clk = ~clk;

  stream_prefix #(.DW(DW), .CW(CW)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .MODE          (mode),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .PKT_CNT       (pkt_cnt),
    .BUSY          (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words of the current packet, expected outputs, packet count.
  bit            m_in_pkt = 1'b0;
  logic [1:0]    m_mode = 2'd0;
  logic [31:0]   cur[$];
  logic [32:0]   exp_q[$];
  logic [32:0]   got_q[$];
  logic [32:0]   want[$];
  logic [CW-1:0] exp_cnt = '0;
  bit            prev_stall = 1'b0;
  logic [32:0]   prev_dat = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected result from packet history: sum of all words so far, or word minus previous word.
  task automatic model_accept(input logic [1:0] md, input logic [31:0] d, input bit last);
    logic [31:0] r;
    if (!m_in_pkt) begin
      m_mode = md;
      cur.delete();
    end
    cur.push_back(d);
    case (m_mode)
      2'd1: begin
        r = '0;
        foreach (cur[i]) r = r + cur[i];
      end
      2'd2: r = (cur.size() > 1) ? d - cur[cur.size()-2] : d;
      default: r = d;
    endcase
    exp_q.push_back({last, r});
    m_in_pkt = !last;
    if (last) cur.delete();
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    m_in_pkt = 1'b0;
    exp_cnt  = '0;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] md, input logic [31:0] d, input bit last);
    bit ok;
    ok = 1'b0;
    mode     = md;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h never accepted", d);
    end else begin
      @(posedge clk); #1;
      model_accept(md, d, last);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !m_tvalid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
  endtask

  // Compare the recorded output log against a hand-written list, then clear it.
  task automatic expect_log(input string name);
    check({name, "_len"}, 64'(got_q.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_%0d", name, i), 64'(got_q[i]), 64'(want[i]));
    end
    got_q.delete();
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
      check("busy", 64'(busy), 64'(m_in_pkt || exp_q.size() != 0));
      check("tstrb", 64'(m_tstrb), 64'(4'hf));
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'(1));
        check("stall_data", 64'({m_tlast, m_tdata}), 64'(prev_dat));
      end
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %0h expected no beat", {m_tlast, m_tdata});
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("out_beat", 64'({m_tlast, m_tdata}), 64'(e));
          if (e[32]) exp_cnt = exp_cnt + 1'b1;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = {m_tlast, m_tdata};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_pktcnt", 64'(pkt_cnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("tready_before_edge", 64'(s_tready), 64'(0));
    @(posedge clk); #1;
    check("tready_after_edge", 64'(s_tready), 64'(1));

    // Prefix sum with one-cycle latency checks on each beat.
    send(2'd1, 32'd1, 1'b0);
    check("lat_v0", 64'(m_tvalid), 64'(1));
    check("lat_d0", 64'(m_tdata), 64'(1));
    send(2'd1, 32'd2, 1'b0);
    check("lat_d1", 64'(m_tdata), 64'(3));
    send(2'd1, 32'd3, 1'b0);
    check("lat_d2", 64'(m_tdata), 64'(6));
    send(2'd1, 32'd4, 1'b1);
    check("lat_d3", 64'(m_tdata), 64'(10));
    check("lat_l3", 64'(m_tlast), 64'(1));
    idle();
    drain();
    want = '{33'h0_00000001, 33'h0_00000003, 33'h0_00000006, 33'h1_0000000A};
    expect_log("psum");
    check("psum_pktcnt", 64'(pkt_cnt), 64'(1));

    // Difference packet with wrap, then a one-beat prefix-sum packet.
    send(2'd2, 32'd5, 1'b0);
    send(2'd2, 32'd7, 1'b0);
    send(2'd2, 32'd4, 1'b1);
    send(2'd1, 32'd9, 1'b1);
    idle();
    drain();
    want = '{33'h0_00000005, 33'h0_00000002, 33'h1_FFFFFFFD, 33'h1_00000009};
    expect_log("diff");
    check("diff_pktcnt", 64'(pkt_cnt), 64'(3));

    // Prefix sum wrapping past 2^32.
    send(2'd1, 32'hFFFFFFFF, 1'b0);
    send(2'd1, 32'd2, 1'b0);
    send(2'd1, 32'd3, 1'b1);
    idle();
    drain();
    want = '{33'h0_FFFFFFFF, 33'h0_00000001, 33'h1_00000004};
    expect_log("wrap");

    // Backpressure: four stalled output cycles in the middle of a continuous stream.
    fork
      begin
        for (int v = 10; v < 20; v++) send(2'd0, 32'(v), v == 19);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        check("bp_tready_one_buffered", 64'(s_tready), 64'(1));
        @(negedge clk);
        check("bp_tready_dropped", 64'(s_tready), 64'(0));
        check("bp_main_data", 64'(m_tdata), 64'(13));
        repeat (3) @(posedge clk);
        #1;
        check("bp_tready_still_low", 64'(s_tready), 64'(0));
        m_tready = 1'b1;
      end
    join
    drain();
    want.delete();
    for (int v = 10; v < 20; v++) want.push_back({v == 19, 32'(v)});
    expect_log("bp");
    check("bp_pktcnt", 64'(pkt_cnt), 64'(5));

    // Mid-packet MODE change is ignored; following packets use the new mode; mode 3 passes.
    send(2'd1, 32'd1, 1'b0);
    send(2'd1, 32'd1, 1'b0);
    send(2'd2, 32'd1, 1'b1);
    send(2'd2, 32'd5, 1'b0);
    send(2'd2, 32'd8, 1'b1);
    send(2'd3, 32'd6, 1'b0);
    send(2'd3, 32'd2, 1'b1);
    idle();
    drain();
    want = '{33'h0_00000001, 33'h0_00000002, 33'h1_00000003,
             33'h0_00000005, 33'h1_00000003,
             33'h0_00000006, 33'h1_00000002};
    expect_log("modesw");
    check("modesw_pktcnt", 64'(pkt_cnt), 64'(8));

    // Reset in the middle of a prefix-sum packet.
    send(2'd1, 32'd4, 1'b0);
    send(2'd1, 32'd4, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    want = '{33'h0_00000004, 33'h0_00000008};
    expect_log("prerst");
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_tready", 64'(s_tready), 64'(0));
    check("midrst_tvalid", 64'(m_tvalid), 64'(0));
    check("midrst_tdata", 64'(m_tdata), 64'(0));
    check("midrst_tlast", 64'(m_tlast), 64'(0));
    check("midrst_pktcnt", 64'(pkt_cnt), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(2'd1, 32'd7, 1'b1);
    idle();
    drain();
    want = '{33'h1_00000007};
    expect_log("postrst");
    check("postrst_pktcnt", 64'(pkt_cnt), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
